// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Multi-cycle radix-2 non-restoring divider (DIV/DIVU) for the
//               execute stage, one quotient bit per cycle. The result is
//               {remainder, quotient} for HI/LO. The optional macro
//               DIV_SKIP_TRIVIAL_EN finishes in one edge when |dividend| < |divisor|.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_divzero = 2'd1;
    localparam logic [1:0] c_st_on      = 2'd2;
    localparam logic [1:0] c_st_end     = 2'd3;

    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_dvs_ext;
    logic [WIDTH:0]     w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;
    logic [WIDTH:0]     w_fix_rem;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quo_out;
    logic [WIDTH-1:0]   w_rem_out;
    logic               w_abort;

    // Magnitudes; the most negative value maps onto itself, read as unsigned.
    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The dividend drains out of the top of r_quo while quotient bits fill the bottom.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_dvs_ext  = {1'b0, r_dvs};
    assign w_step_rem = r_rem[WIDTH] ? (w_shift + w_dvs_ext) : (w_shift - w_dvs_ext);
    assign w_step_quo = {r_quo[WIDTH-2:0], ~w_step_rem[WIDTH]};

    // A negative final remainder is restored once by adding the divisor back.
    assign w_fix_rem  = w_step_rem[WIDTH] ? (w_step_rem + w_dvs_ext) : w_step_rem;
    assign w_rem_mag  = w_fix_rem[WIDTH-1:0];
    assign w_quo_out  = r_neg_q ? -w_step_quo : w_step_quo;
    assign w_rem_out  = r_neg_r ? -w_rem_mag : w_rem_mag;

    assign w_abort    = annul_i || !start_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_ready <= 1'b0;
                    if (annul_i) begin
                        r_state <= c_st_idle;
                    end else if (start_i) begin
                        if (opdata2_i == '0) begin
                            r_dividend <= opdata1_i;
                            r_state    <= c_st_divzero;
                        end
`ifdef DIV_SKIP_TRIVIAL_EN
                        else if (w_abs1 < w_abs2) begin
                            r_result <= {opdata1_i, {WIDTH{1'b0}}};
                            r_ready  <= 1'b1;
                            r_state  <= c_st_end;
                        end
`endif
                        else begin
                            r_dividend <= opdata1_i;
                            r_rem      <= '0;
                            r_quo      <= w_abs1;
                            r_dvs      <= w_abs2;
                            r_neg_q    <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg_r    <= signed_div_i && opdata1_i[WIDTH-1];
                            r_cnt      <= '0;
                            r_state    <= c_st_on;
                        end
                    end
                end

                c_st_divzero: begin
                    if (w_abort) begin
                        r_ready <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_result <= {r_dividend, {WIDTH{1'b1}}};
                        r_ready  <= 1'b1;
                        r_state  <= c_st_end;
                    end
                end

                c_st_on: begin
                    if (w_abort) begin
                        r_ready <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_last) begin
                            r_result <= {w_rem_out, w_quo_out};
                            r_ready  <= 1'b1;
                            r_state  <= c_st_end;
                        end
                    end
                end

                c_st_end: begin
                    if (w_abort) begin
                        r_ready <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Directed vector bench for div_iter: latency, signed/unsigned
//               results, divide-by-zero, abort, hold and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    localparam int W = 32;
`ifdef DIV_SKIP_TRIVIAL_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 33;
`endif
    localparam int NVEC = 13;

    logic           clk;
    logic           rst;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int             n_checks;
    int             n_fail;
    logic [2*W-1:0] last_res;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        int             lat;
    } vec_t;

    vec_t vecs [NVEC];

    div_iter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   n;
        logic busy_ok;
        logic [2*W-1:0] held;
        @(negedge clk);
        sgn   = v.sgn;
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        n       = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_ok = 1'b0;
            // Operands must have been captured at accept.
            if (n == 1) begin
                a = 32'hDEAD_BEEF;
                b = 32'h0000_0000;
                sgn = ~sgn;
            end
        end while (!ready && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(v.lat));
        chk({tag, " result"}, result, v.res);
        chk({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
        held = result;
        @(posedge clk);
        #1;
        chk({tag, " hold"}, {ready, result[2*W-2:0]} ^ {1'b0, 63'd0}, {1'b1, held[2*W-2:0]});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release"}, {62'd0, ready, busy}, 64'd0);
        last_res = v.res;
    endtask

    task automatic abort_seq(input bit use_annul, input string tag);
        logic rose;
        @(negedge clk);
        sgn   = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0003;
        start = 1'b1;
        rose  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ready) rose = 1'b1;
        end
        @(negedge clk);
        if (use_annul) annul = 1'b1;
        else           start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " idle"}, {62'd0, ready, busy}, 64'd0);
        chk({tag, " result kept"}, result, last_res);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        if (ready) rose = 1'b1;
        chk({tag, " no ready"}, {63'd0, rose}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_res = '0;
        rst   = 1'b1;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        start = 1'b0;
        annul = 1'b0;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33};
        vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, LAT_SMALL};
        vecs[5]  = '{1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF, 2};
        vecs[6]  = '{1'b0, 32'd3,         32'd10,        64'h00000003_00000000, LAT_SMALL};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'd3,         64'h00000000_55555555, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 33};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33};
        vecs[10] = '{1'b1, 32'd0,         32'd5,         64'h00000000_00000000, LAT_SMALL};
        vecs[11] = '{1'b1, 32'hFFFFFFFB,  32'd0,         64'hFFFFFFFB_FFFFFFFF, 2};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'h00010000,  64'h0000FFFF_0000FFFF, 33};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {result[2*W-1:2], ready, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        abort_seq(1'b1, "annul");
        run_vec('{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33}, "after annul");
        abort_seq(1'b0, "start drop");
        run_vec('{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33}, "after drop");

        // Synchronous reset in the middle of an iteration.
        @(negedge clk);
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid-on busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-on reset result", result, 64'd0);
        chk("mid-on reset flags", {62'd0, ready, busy}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("post reset idle", {62'd0, ready, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
